seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Reads a time-multiplexed, active-low 4-digit 7-segment bus (segment lines plus digit-select lines) and recovers the displayed 16-bit hex value.
- Inverse of the team's hex-to-7-segment display path. Used for display loopback checking and for reading scanned panel outputs back into the datapath.
- Filters each digit's pattern for stability, decodes it to a nibble, and assembles a frame.
- Flags invalid or blank patterns per digit, and flags frames that never complete.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples (same digit and same pattern) required before a capture. Legal range 2..255.
- TIMEOUT_CYCLES, 65536: cycles allowed from the first capture of a frame to frame completion. Minimum 16.

Ports:
- Clock  in  1  system clock. All logic is rising-edge.
- Reset  in  1  synchronous, active-high reset.
- seg_n  in  7  segment lines, active-low. bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- dig_n  in  4  digit selects, active-low. bit k low means digit k is driven. Digit 3 is the most significant nibble.
- value  out  16  last completed frame. Nibble k comes from digit k.
- blank  out  4  bit k set when digit k showed all segments off in the last frame.
- err  out  4  bit k set when digit k showed a non-hex, non-blank pattern in the last frame.
- frame_valid  out  1  one-cycle pulse when value, blank and err update.
- timeout  out  1  one-cycle pulse when a partial frame is abandoned.

Behaviour:
- Reset: value=0, blank=0, err=0, frame_valid=0, timeout=0. Also clears the input register, stability counter, slot registers, captured mask and timeout counter. Reset mid-frame discards the partial frame with no pulse.
- Input stage: seg_n and dig_n are registered once; all later logic uses the registered copy.
- Select validity: a sample is valid only when dig_n has exactly one zero bit. That bit gives digit index k.
  - dig_n=4'b1111, or more than one zero: stability counter forced to 0, no capture.
- Stability counter (8 bits, saturating at STABLE_CYCLES):
  - Loads 1 when a valid sample differs from the previous sample in k or in pattern.
  - Increments while the sample is valid and identical to the previous one.
- Capture: fires on the edge the counter transitions to STABLE_CYCLES. It fires exactly once per stable run; a static held digit is captured once, not repeatedly.
- Capture latency: pattern applied before edge 1 and held gives a slot write at edge STABLE_CYCLES+1.
- Decode, with active-low pattern written as bits g..a in hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=18 (no d segment), A=08, b=03, C=46, d=21, E=06, F=0E
  - 7F = blank: nibble 0, blank bit set.
  - Any other pattern: nibble 0, err bit set.
- Slot k write: stores nibble, blank bit and err bit, and sets captured[k]. A re-capture of digit k within the same frame overwrites the slot (latest wins).
- Frame completion: on the edge captured becomes 4'b1111:
  - slots are copied to value/blank/err on that edge, so they include the slot just captured;
  - frame_valid is high in the following cycle;
  - captured is cleared to 0 on that edge.
- Timeout counter:
  - Starts at the first capture while captured==0, and counts every cycle.
  - Reaching TIMEOUT_CYCLES-1 without completion: timeout pulses one cycle and captured clears.
  - value/blank/err keep their previous values.
- Simultaneous events: if completion and timeout land on the same edge, completion wins and timeout stays 0.
- Outputs hold between frames. frame_valid and timeout are never high together.

Decomposition:
- Package seg7_pkg holds:
  - the 16 pattern constants SEG_HEX_0..SEG_HEX_F and SEG_BLANK (7'h7F);
  - the digit count constant NUM_DIGITS=4;
  - a slot struct typedef {nibble[3:0], blank, err}.
- Sub-module seg7_to_hex: purely combinational. Input 7-bit pattern; outputs nibble[3:0], blank, err.
  - Used once per capture path.
  - Shares the package constants with the display encoder so both directions stay consistent.

Test Plan:
- Scan digits 3..0 with patterns 30,12,08,46, each dwell 6 cycles, STABLE_CYCLES=4 -> frame_valid pulses once, value=16'h35AC, blank=0, err=0.
- Dwell of 3 cycles for digit 1, with digits 0, 2 and 3 showing valid hex patterns and dwell ≥6 -> digit 1 never captured, no frame_valid. After TIMEOUT_CYCLES, timeout pulses, value unchanged.
- Digit 2 shows 7F and digit 0 shows 7E, with digits 1 and 3 showing valid hex patterns and dwell ≥6 -> frame_valid, blank=4'b0100, err=4'b0001, nibbles 2 and 0 read 0.
- 9 shown as 18 vs the common 10 form -> 18 decodes to nibble 9 with err=0. 10 sets err.
- dig_n=4'b1100 glitch for 2 cycles inside a dwell -> stability counter restarts, capture delayed by STABLE_CYCLES+1 from glitch end, value still correct.
- Reset asserted after 3 of 4 digits captured -> outputs 0, no pulse. Next full scan yields one correct frame.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern constants and slot type for encode/decode paths
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    // Active-low patterns, bits g..a
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h18;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       err;
    } slot_t;
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational decode of an active-low 7-segment pattern to a nibble
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);
    always_comb begin
        nibble = 4'h0;
        blank  = seg == SEG_BLANK;
        err    = 1'b0;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            SEG_BLANK: nibble = 4'h0;
            default:   err    = 1'b1;
        endcase
    end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers a 16-bit hex value from a scanned active-low 4-digit 7-segment bus
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_n,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic        timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [6:0]    seg_q, prev_seg;
    logic [3:0]    dig_q, prev_dig, sel, captured, cap_mask, nx_blank, nx_err;
    logic [7:0]    cnt;
    logic [TW-1:0] tcnt;
    logic [1:0]    k;
    logic [3:0]    dec_nib;
    logic          dec_blank, dec_err, valid, same, cap, complete, expire;
    logic [15:0]   nx_value;
    slot_t         slots  [NUM_DIGITS];
    slot_t         slot_nx[NUM_DIGITS];
    seg7_to_hex u_dec (
        .seg    (seg_q),
        .nibble (dec_nib),
        .blank  (dec_blank),
        .err    (dec_err)
    );
    assign sel      = ~dig_q;
    assign valid    = $onehot(sel);
    assign same     = dig_q == prev_dig && seg_q == prev_seg;
    // Capture on the single edge the run length reaches STABLE_CYCLES
    assign cap      = valid && same && cnt == 8'(STABLE_CYCLES - 1);
    assign cap_mask = captured | (cap ? sel : 4'b0000);
    assign complete = cap && cap_mask == 4'hF;
    assign expire   = |captured && tcnt == TW'(TIMEOUT_CYCLES - 1) && !complete;
    always_comb begin
        k = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (sel[i]) k = 2'(i);
    end
    // Completion publishes the slot being written on the same edge
    always_comb begin
        slot_nx = slots;
        if (cap) slot_nx[k] = '{nibble: dec_nib, blank: dec_blank, err: dec_err};
        nx_value = '0;
        nx_blank = '0;
        nx_err   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nx_value[4*i +: 4] = slot_nx[i].nibble;
            nx_blank[i]        = slot_nx[i].blank;
            nx_err[i]          = slot_nx[i].err;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= '0;
            dig_q       <= '0;
            prev_seg    <= '0;
            prev_dig    <= '0;
            cnt         <= '0;
            tcnt        <= '0;
            captured    <= '0;
            value       <= '0;
            blank       <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= '0;
        end else begin
            seg_q       <= seg_n;
            dig_q       <= dig_n;
            prev_seg    <= seg_q;
            prev_dig    <= dig_q;
            cnt         <= !valid ? 8'd0 : !same ? 8'd1 :
                           cnt == 8'(STABLE_CYCLES) ? cnt : cnt + 8'd1;
            tcnt        <= captured == 4'b0000 ? '0 : tcnt + 1'b1;
            captured    <= complete || expire ? 4'b0000 : cap_mask;
            frame_valid <= complete;
            timeout     <= expire;
            slots       <= slot_nx;
            if (complete) begin
                value <= nx_value;
                blank <= nx_blank;
                err   <= nx_err;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed table-driven bench for the scanned 7-segment decoder
module tb_seg7_scan_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic [15:0] value;
    logic [3:0]  blank, err;
    logic        frame_valid, timeout;
    int n_checks = 0;
    int n_fail = 0;
    int fv_cnt = 0;
    int to_cnt = 0;
    int both_cnt = 0;

    seg7_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .value       (value),
        .blank       (blank),
        .err         (err),
        .frame_valid (frame_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (timeout) to_cnt++;
        if (frame_valid && timeout) both_cnt++;
    end

    typedef struct {
        logic [6:0]  p3, p2, p1, p0;
        logic [15:0] v;
        logic [3:0]  b, e;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [6:0] pat, input int n);
        dig_n = 4'hF;
        dig_n[d] = 1'b0;
        seg_n = pat;
        repeat (n) step();
    endtask

    task automatic idle(input int n);
        dig_n = 4'hF;
        seg_n = 7'h7F;
        repeat (n) step();
    endtask

    task automatic scan(input logic [6:0] p3, p2, p1, p0, input int dw1);
        drive(3, p3, 6);
        drive(2, p2, 6);
        drive(1, p1, dw1);
        drive(0, p0, 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0, to0, lat;
        tbl[0] = '{7'h30, 7'h12, 7'h08, 7'h46, 16'h35AC, 4'b0000, 4'b0000};
        tbl[1] = '{7'h79, 7'h7F, 7'h24, 7'h7E, 16'h1020, 4'b0100, 4'b0001};
        tbl[2] = '{7'h18, 7'h10, 7'h40, 7'h0E, 16'h900F, 4'b0000, 4'b0100};
        tbl[3] = '{7'h00, 7'h78, 7'h02, 7'h19, 16'h8764, 4'b0000, 4'b0000};
        tbl[4] = '{7'h03, 7'h21, 7'h06, 7'h0E, 16'hBDEF, 4'b0000, 4'b0000};
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset value", 32'(value), 32'h0);
        check("reset blank", 32'(blank), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset frame_valid", 32'(frame_valid), 32'h0);
        check("reset timeout", 32'(timeout), 32'h0);

        for (int i = 0; i < 5; i++) begin
            fv0 = fv_cnt;
            idle(2);
            scan(tbl[i].p3, tbl[i].p2, tbl[i].p1, tbl[i].p0, 6);
            idle(4);
            check($sformatf("vec%0d frame_valid pulses", i), 32'(fv_cnt - fv0), 32'd1);
            check($sformatf("vec%0d value", i), 32'(value), 32'(tbl[i].v));
            check($sformatf("vec%0d blank", i), 32'(blank), 32'(tbl[i].b));
            check($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].e));
        end

        fv0 = fv_cnt;
        to0 = to_cnt;
        for (int r = 0; r < 8 && to_cnt == to0; r++)
            scan(7'h30, 7'h12, 7'h08, 7'h46, 3);
        check("short dwell timeout pulses", 32'(to_cnt - to0), 32'd1);
        check("short dwell no frame", 32'(fv_cnt - fv0), 32'd0);
        check("timeout value held", 32'(value), 32'hBDEF);
        check("timeout blank held", 32'(blank), 32'h0);
        check("timeout err held", 32'(err), 32'h0);
        idle(80);

        fv0 = fv_cnt;
        idle(2);
        drive(3, 7'h30, 6);
        drive(2, 7'h12, 6);
        drive(1, 7'h08, 6);
        drive(0, 7'h46, 2);
        dig_n = 4'b1100;
        repeat (2) step();
        dig_n = 4'b1110;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (frame_valid && lat == 0) lat = i;
        end
        idle(4);
        check("glitch capture latency", 32'(lat), 32'd5);
        check("glitch value", 32'(value), 32'h35AC);
        check("glitch frame_valid pulses", 32'(fv_cnt - fv0), 32'd1);

        fv0 = fv_cnt;
        to0 = to_cnt;
        idle(2);
        drive(3, 7'h00, 6);
        drive(2, 7'h78, 6);
        drive(1, 7'h02, 6);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        idle(2);
        check("midframe reset value", 32'(value), 32'h0);
        check("midframe reset blank", 32'(blank), 32'h0);
        check("midframe reset err", 32'(err), 32'h0);
        check("midframe reset no frame", 32'(fv_cnt - fv0), 32'd0);
        check("midframe reset no timeout", 32'(to_cnt - to0), 32'd0);
        scan(7'h00, 7'h78, 7'h02, 7'h19, 6);
        idle(4);
        check("after reset frame pulses", 32'(fv_cnt - fv0), 32'd1);
        check("after reset value", 32'(value), 32'h8764);
        check("frame_valid with timeout", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
